pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Multicycle control FSM that sequences the PC-update datapath (PC register, PC+2 adder, next-PC mux, return stack). Each instruction passes through FETCH, DECODE and EXEC. In EXEC the block drives PCWrite, PCControl and RStackOP so the PC advances, jumps, branches, calls or returns. It also tracks return-stack depth, halts on stack misuse, and counts retired instructions.

## Interface
- DEPTH, 16: return-stack capacity in entries; must match the return_stack instance.
- CLK  in  1  clock; all state changes on the rising edge.
- Reset  in  1  synchronous, active-high.
- InstValid  in  1  instruction memory data valid; sampled in FETCH.
- Op  in  3  decoded class: 0 SEQ, 1 JUMP, 2 BRANCH, 3 CALL, 4 RET, 5 HALT, 6–7 illegal.
- CondTrue  in  1  branch condition; sampled in EXEC.
- Stall  in  1  holds EXEC when 1; no datapath writes that cycle.
- IRWrite  out  1  load instruction register.
- PCWrite  out  1  PC load enable.
- PCControl  out  3  next-PC select: 0 return-stack top, 1 target, 4 PC+2.
- RStackOP  out  2  0 hold, 1 push PC+2, 2 pop.
- Halted  out  1  sequencer is in HALTED.
- StackError  out  1  sticky; set on push when full or pop when empty.
- Depth  out  log2(DEPTH)+1  current return-stack occupancy.
- Retired  out  16  count of completed instructions; wraps at 0xFFFF→0.

## Operation
- States: FETCH, DECODE, EXEC, HALTED.
- FETCH:
  - InstValid=1 → IRWrite=1, go to DECODE.
  - Otherwise stay in FETCH; all outputs idle.
- DECODE: register Op into OpR. Outputs idle. Go to EXEC.
- EXEC with Stall=1: stay in EXEC, outputs idle.
- EXEC with Stall=0, by OpR:
  - SEQ: PCWrite=1, PCControl=4.
  - JUMP: PCWrite=1, PCControl=1.
  - BRANCH: PCWrite=1; PCControl=1 if CondTrue=1, else 4.
  - CALL with Depth<DEPTH: PCWrite=1, PCControl=1, RStackOP=1, Depth+1. The value pushed is PC+2 of the current PC, on the same edge as the PC load.
  - RET with Depth>0: PCWrite=1, PCControl=0, RStackOP=2, Depth−1.
- Every non-halting EXEC with Stall=0 increments Retired and returns to FETCH.
- Error and halt cases (no PCWrite, no stack op, Retired unchanged, next state HALTED):
  - CALL with Depth==DEPTH: StackError←1.
  - RET with Depth==0: StackError←1.
  - HALT or an illegal Op (6–7): StackError unchanged.
- HALTED: all control outputs 0 and Halted=1. Only Reset leaves HALTED.
- Idle means PCWrite=0, IRWrite=0, RStackOP=0, PCControl=4.
- Control outputs are combinational from state, OpR, CondTrue and Stall. All other outputs are registered.

## Timing
- Reset has priority over every other input.
  - State←FETCH; Depth, Retired, StackError, OpR all ←0.
  - Output values in the reset cycle: PCWrite=0, IRWrite=0, RStackOP=0, PCControl=4, Halted=0.
  - Reset asserted mid-EXEC suppresses that cycle's writes on the same edge.
- Minimum latency is 3 cycles per instruction (FETCH with valid, DECODE, EXEC). Each FETCH wait cycle or Stall cycle adds 1.
- Exactly one PCWrite pulse per retired instruction, in the final EXEC cycle.
- Depth and Retired update on the same edge as PCWrite.
- Halted rises the cycle after the halting EXEC.
- InstValid is ignored outside FETCH. Op is ignored outside DECODE. CondTrue is ignored outside EXEC.
- Depth boundaries:
  - Depth==DEPTH−1 then CALL → Depth=DEPTH, legal.
  - A further CALL → error.
  - Depth never wraps.

## Test plan
- Reset then SEQ ×3, InstValid always 1: PCWrite pulses in cycles 3, 6, 9 with PCControl=4; Retired=3; PC 0→2→4→6.
- BRANCH with CondTrue=0 then BRANCH with CondTrue=1: PCControl=4 then 1; each has a single PCWrite pulse.
- CALL then RET: CALL cycle RStackOP=1, PCControl=1, Depth 0→1. RET cycle RStackOP=2, PCControl=0, Depth→0, and PC equals the call-site PC+2.
- Overflow at DEPTH=16: 17 CALLs leave Depth=16, StackError=1, Halted=1, Retired=16. A following InstValid=1 produces no IRWrite.
- Underflow: RET from reset gives StackError=1, Halted=1, no PCWrite, Retired=0.
- Stall and Reset: Stall held 4 cycles in EXEC gives no writes and PCWrite only after release. Reset asserted during a stalled CALL gives Depth=0, state FETCH, no push.

Source files
------------

// File: rtl/pc_sequencer.sv
// Multicycle FETCH/DECODE/EXEC control for the PC-update datapath: drives PC load,
// next-PC select and return-stack ops, tracks stack depth and counts retired instructions.
module pc_sequencer #(
  parameter int unsigned DEPTH = 16,
  localparam int unsigned DW = $clog2(DEPTH) + 1
) (
  input  logic          CLK,
  input  logic          Reset,
  input  logic          InstValid,
  input  logic [2:0]    Op,
  input  logic          CondTrue,
  input  logic          Stall,
  output logic          IRWrite,
  output logic          PCWrite,
  output logic [2:0]    PCControl,
  output logic [1:0]    RStackOP,
  output logic          Halted,
  output logic          StackError,
  output logic [DW-1:0] Depth,
  output logic [15:0]   Retired
);

  typedef enum logic [1:0] {StFetch, StDecode, StExec, StHalted} state_e;

  localparam logic [2:0] OpSeq    = 3'd0;
  localparam logic [2:0] OpJump   = 3'd1;
  localparam logic [2:0] OpBranch = 3'd2;
  localparam logic [2:0] OpCall   = 3'd3;
  localparam logic [2:0] OpRet    = 3'd4;

  localparam logic [2:0] PcSelStack  = 3'd0;
  localparam logic [2:0] PcSelTarget = 3'd1;
  localparam logic [2:0] PcSelInc    = 3'd4;

  localparam logic [1:0] RsHold = 2'd0;
  localparam logic [1:0] RsPush = 2'd1;
  localparam logic [1:0] RsPop  = 2'd2;

  localparam logic [DW-1:0] DepthMax = DW'(DEPTH);
  localparam logic [DW-1:0] DepthOne = DW'(1);

  state_e        state_q, state_d;
  logic [2:0]    op_q, op_d;
  logic [DW-1:0] depth_q, depth_d;
  logic [15:0]   retired_q, retired_d;
  logic          err_q, err_d;
  logic          halted_q, halted_d;
  logic          retire;

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    depth_d   = depth_q;
    retired_d = retired_q;
    err_d     = err_q;
    retire    = 1'b0;
    IRWrite   = 1'b0;
    PCWrite   = 1'b0;
    PCControl = PcSelInc;
    RStackOP  = RsHold;

    unique case (state_q)
      StFetch: begin
        if (InstValid) begin
          IRWrite = 1'b1;
          state_d = StDecode;
        end
      end
      StDecode: begin
        op_d    = Op;
        state_d = StExec;
      end
      StExec: begin
        if (!Stall) begin
          retire = 1'b1;
          case (op_q)
            OpSeq: PCWrite = 1'b1;
            OpJump: begin
              PCWrite   = 1'b1;
              PCControl = PcSelTarget;
            end
            OpBranch: begin
              PCWrite   = 1'b1;
              PCControl = CondTrue ? PcSelTarget : PcSelInc;
            end
            OpCall: begin
              if (depth_q < DepthMax) begin
                PCWrite   = 1'b1;
                PCControl = PcSelTarget;
                RStackOP  = RsPush;
                depth_d   = depth_q + DepthOne;
              end else begin
                retire = 1'b0;
                err_d  = 1'b1;
              end
            end
            OpRet: begin
              if (depth_q != '0) begin
                PCWrite   = 1'b1;
                PCControl = PcSelStack;
                RStackOP  = RsPop;
                depth_d   = depth_q - DepthOne;
              end else begin
                retire = 1'b0;
                err_d  = 1'b1;
              end
            end
            default: retire = 1'b0;
          endcase
          state_d = retire ? StFetch : StHalted;
          if (retire) retired_d = retired_q + 16'd1;
        end
      end
      StHalted: PCControl = 3'd0;
      default: state_d = StFetch;
    endcase

    // Reset wins on the same edge and also masks this cycle's datapath writes.
    if (Reset) begin
      state_d   = StFetch;
      op_d      = '0;
      depth_d   = '0;
      retired_d = '0;
      err_d     = 1'b0;
      IRWrite   = 1'b0;
      PCWrite   = 1'b0;
      PCControl = PcSelInc;
      RStackOP  = RsHold;
    end

    halted_d = (state_d == StHalted);
  end

  always_ff @(posedge CLK) begin
    state_q   <= state_d;
    op_q      <= op_d;
    depth_q   <= depth_d;
    retired_q <= retired_d;
    err_q     <= err_d;
    halted_q  <= halted_d;
  end

  assign Halted     = halted_q & ~Reset;
  assign StackError = err_q;
  assign Depth      = depth_q;
  assign Retired    = retired_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer with a small PC/return-stack datapath model.
module tb_pc_sequencer;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned DW = $clog2(DEPTH) + 1;

  logic          CLK = 1'b0;
  logic          Reset = 1'b1;
  logic          InstValid = 1'b0;
  logic [2:0]    Op = 3'd0;
  logic          CondTrue = 1'b0;
  logic          Stall = 1'b0;
  logic          IRWrite, PCWrite, Halted, StackError;
  logic [2:0]    PCControl;
  logic [1:0]    RStackOP;
  logic [DW-1:0] Depth;
  logic [15:0]   Retired;

  pc_sequencer #(.DEPTH(DEPTH)) dut (
    .CLK(CLK), .Reset(Reset), .InstValid(InstValid), .Op(Op), .CondTrue(CondTrue),
    .Stall(Stall), .IRWrite(IRWrite), .PCWrite(PCWrite), .PCControl(PCControl),
    .RStackOP(RStackOP), .Halted(Halted), .StackError(StackError), .Depth(Depth),
    .Retired(Retired)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Datapath driven by DUT outputs: PC register and return stack.
  logic [15:0] pc_q;
  logic [15:0] tgt = 16'h0;
  logic [15:0] stk [DEPTH];
  int          sp;

  always @(posedge CLK) begin
    if (Reset) begin
      pc_q <= 16'h0;
      sp   <= 0;
    end else begin
      if (PCWrite) begin
        case (PCControl)
          3'd0:    pc_q <= (sp > 0) ? stk[sp-1] : 16'hDEAD;
          3'd1:    pc_q <= tgt;
          default: pc_q <= pc_q + 16'd2;
        endcase
      end
      if (RStackOP == 2'd1 && sp < DEPTH) begin
        stk[sp] <= pc_q + 16'd2;
        sp      <= sp + 1;
      end else if (RStackOP == 2'd2 && sp > 0) begin
        sp <= sp - 1;
      end
    end
  end

  int cyc;
  always @(posedge CLK) cyc <= Reset ? 1 : cyc + 1;

  typedef struct {
    logic [2:0]    pcctl;
    logic [1:0]    rsop;
    logic [DW-1:0] depth;
    logic [15:0]   retired;
    logic [15:0]   pc;
  } exp_t;
  exp_t sb[$];

  // Reference model, updated when an instruction is decoded.
  int          m_depth, m_retired;
  logic        m_err;
  logic [15:0] m_pc;
  logic [15:0] m_stk [DEPTH];
  int          pcw_cyc[$];

  always @(negedge CLK) begin
    exp_t cur;
    if (!Reset && PCWrite) begin
      if (sb.size() == 0) begin
        check_val("spurious_pcwrite", 1, 0);
      end else begin
        cur = sb.pop_front();
        check_val("pcctl", PCControl, cur.pcctl);
        check_val("rsop", RStackOP, cur.rsop);
        @(posedge CLK);
        #1;
        check_val("depth_after", Depth, cur.depth);
        check_val("retired_after", Retired, cur.retired);
        check_val("pc_after", pc_q, cur.pc);
      end
    end
  end

  task automatic model_clear();
    m_depth = 0;
    m_retired = 0;
    m_err = 1'b0;
    m_pc = 16'h0;
    sb.delete();
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    InstValid = 1'b1;
    Stall = 1'b0;
    @(negedge CLK);
    check_val("rst_pcwrite", PCWrite, 0);
    check_val("rst_irwrite", IRWrite, 0);
    check_val("rst_rsop", RStackOP, 0);
    check_val("rst_pcctl", PCControl, 4);
    check_val("rst_halted", Halted, 0);
    @(posedge CLK);
    #1;
    Reset = 1'b0;
    InstValid = 1'b0;
    check_val("rst_depth", Depth, 0);
    check_val("rst_retired", Retired, 0);
    check_val("rst_err", StackError, 0);
    model_clear();
  endtask

  // Runs one instruction starting in FETCH; returns just after the EXEC edge.
  task automatic run_inst(input logic [2:0] op, input bit cond, input int nwait,
                          input int nstall, input bit rst_in_stall = 1'b0);
    bit          legal;
    exp_t        e;
    tgt = 16'($urandom) & 16'hFFFE;
    for (int w = 0; w < nwait; w++) begin
      InstValid = 1'b0;
      Op = 3'($urandom);
      @(negedge CLK);
      check_val("irwrite_wait", IRWrite, 0);
      check_val("pcwrite_fetch", PCWrite, 0);
      @(posedge CLK);
      #1;
    end
    InstValid = 1'b1;
    @(negedge CLK);
    check_val("irwrite_fetch", IRWrite, 1);
    @(posedge CLK);
    #1;
    InstValid = 1'($urandom);
    Op = op;
    @(negedge CLK);
    check_val("decode_idle", {IRWrite, PCWrite, RStackOP, PCControl}, {4'b0, 3'd4});
    legal = 1'b1;
    e.pcctl = 3'd4;
    e.rsop = 2'd0;
    case (op)
      3'd0: m_pc = m_pc + 16'd2;
      3'd1: begin e.pcctl = 3'd1; m_pc = tgt; end
      3'd2: begin
        if (cond) begin e.pcctl = 3'd1; m_pc = tgt; end
        else m_pc = m_pc + 16'd2;
      end
      3'd3: begin
        if (m_depth < DEPTH) begin
          e.pcctl = 3'd1;
          e.rsop = 2'd1;
          m_stk[m_depth] = m_pc + 16'd2;
          m_depth++;
          m_pc = tgt;
        end else begin
          legal = 1'b0;
          m_err = 1'b1;
        end
      end
      3'd4: begin
        if (m_depth > 0) begin
          e.pcctl = 3'd0;
          e.rsop = 2'd2;
          m_depth--;
          m_pc = m_stk[m_depth];
        end else begin
          legal = 1'b0;
          m_err = 1'b1;
        end
      end
      default: legal = 1'b0;
    endcase
    if (legal) begin
      m_retired++;
      e.depth = DW'(m_depth);
      e.retired = 16'(m_retired);
      e.pc = m_pc;
      sb.push_back(e);
    end
    @(posedge CLK);
    #1;
    InstValid = 1'($urandom);
    Op = 3'($urandom);
    for (int s = 0; s < nstall; s++) begin
      Stall = 1'b1;
      CondTrue = 1'($urandom);
      if (rst_in_stall && s == nstall - 1) Reset = 1'b1;
      @(negedge CLK);
      check_val("stall_idle", {PCWrite, RStackOP, IRWrite}, 0);
      check_val("stall_pcctl", PCControl, 4);
      @(posedge CLK);
      #1;
    end
    if (rst_in_stall) begin
      Reset = 1'b0;
      Stall = 1'b0;
      InstValid = 1'b0;
      check_val("rst_stall_depth", Depth, 0);
      check_val("rst_stall_retired", Retired, 0);
      check_val("rst_stall_halted", Halted, 0);
      check_val("rst_stall_sp", sp, 0);
      model_clear();
      return;
    end
    Stall = 1'b0;
    CondTrue = cond;
    @(negedge CLK);
    check_val("pcwrite_exec", PCWrite, legal);
    if (PCWrite) pcw_cyc.push_back(cyc);
    @(posedge CLK);
    #1;
    CondTrue = 1'b0;
    InstValid = 1'b0;
    if (!legal) begin
      check_val("halt_halted", Halted, 1);
      check_val("halt_err", StackError, m_err);
      check_val("halt_depth", Depth, m_depth);
      check_val("halt_retired", Retired, m_retired);
    end
  endtask

  task automatic check_halted_stays();
    for (int i = 0; i < 3; i++) begin
      InstValid = 1'b1;
      @(negedge CLK);
      check_val("halted_irwrite", IRWrite, 0);
      check_val("halted_ctl", {PCWrite, RStackOP, PCControl}, 0);
      check_val("halted_flag", Halted, 1);
      @(posedge CLK);
      #1;
    end
    InstValid = 1'b0;
  endtask

  initial begin
    do_reset();

    // Three back-to-back SEQ: PCWrite in cycles 3, 6, 9.
    pcw_cyc.delete();
    for (int i = 0; i < 3; i++) run_inst(3'd0, 1'b0, 0, 0);
    check_val("seq_pcw_count", pcw_cyc.size(), 3);
    for (int i = 0; i < pcw_cyc.size() && i < 3; i++) check_val("seq_pcw_cycle", pcw_cyc[i], 3 * (i + 1));
    check_val("seq_pc", pc_q, 16'd6);

    run_inst(3'd2, 1'b0, 1, 0);
    run_inst(3'd2, 1'b1, 0, 1);
    run_inst(3'd1, 1'b0, 2, 0);

    run_inst(3'd3, 1'b0, 0, 0);
    run_inst(3'd0, 1'b0, 0, 0);
    run_inst(3'd4, 1'b0, 0, 2);

    // Stall held 4 cycles in EXEC.
    run_inst(3'd0, 1'b0, 0, 4);
    check_val("err_clean", StackError, 0);

    // Reset during a stalled CALL, after a prior CALL made Depth nonzero.
    run_inst(3'd3, 1'b0, 0, 0);
    run_inst(3'd3, 1'b0, 0, 2, 1'b1);
    run_inst(3'd0, 1'b0, 0, 0);

    // Overflow: 17 CALLs.
    do_reset();
    for (int i = 0; i < DEPTH + 1; i++) run_inst(3'd3, 1'b0, i % 2, 0);
    check_val("ovf_depth", Depth, DEPTH);
    check_val("ovf_retired", Retired, DEPTH);
    check_halted_stays();

    // Underflow from reset.
    do_reset();
    run_inst(3'd4, 1'b0, 0, 0);
    check_val("unf_pc", pc_q, 0);
    check_halted_stays();

    // HALT and illegal op leave StackError clear.
    do_reset();
    run_inst(3'd0, 1'b0, 0, 0);
    run_inst(3'd5, 1'b0, 0, 0);
    check_halted_stays();
    do_reset();
    run_inst(3'd7, 1'b1, 0, 1);
    check_val("illegal_err", StackError, 0);

    do_reset();
    run_inst(3'd2, 1'b1, 0, 0);
    check_val("sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
